vga_pixel_engine: RTL and testbench
===================================

// Module: vga_pixel_engine
// PURPOSE
//  Parametrised successor to the fixed 640x480 timing/colour-mux datapath. Generates VGA sync from
//  porch/sync parameters and selects the pixel colour from one of four modes. Colour width per channel
//  is generic. Configuration words are double-buffered and applied only at frame start, so a frame never tears.
//  Sits between the SPI configuration path (cfg_wr/cfg_data) and the board's VGA pins.
// PARAMETERS
//  H_ACTIVE 640  visible pixels per line
//  H_FP     16   horizontal front porch, cycles
//  H_SYNC   96   horizontal sync width, cycles
//  H_BP     48   horizontal back porch, cycles
//  V_ACTIVE 480  visible lines per frame
//  V_FP     10   vertical front porch, lines
//  V_SYNC   2    vertical sync width, lines
//  V_BP     33   vertical back porch, lines
//  CBITS    2    bits per colour channel (1..4)
//  SYNC_POL 0    0 = sync pulses active-low, 1 = active-high
// PORTS
//  clk        in  1          pixel clock
//  rst        in  1          synchronous reset, active-high
//  cfg_wr     in  1          one-cycle strobe; latch cfg_data into the pending register
//  cfg_data   in  32         [31:30] mode, [6*CBITS-1:3*CBITS] fg colour, [3*CBITS-1:0] bg colour; other bits ignored
//  cfg_pending out 1         a pending word is waiting for frame start
//  h_pos      out clog2(HT)  current horizontal counter (unregistered); HT = H_ACTIVE+H_FP+H_SYNC+H_BP
//  v_pos      out clog2(VT)  current vertical counter (unregistered); VT = V_ACTIVE+V_FP+V_SYNC+V_BP
//  src_rand   in  3*CBITS    random colour for (h_pos,v_pos); combinational, same cycle
//  src_char   in  1          glyph bit for (h_pos,v_pos); combinational, same cycle
//  hs, vs     out 1          registered sync outputs
//  rgb        out 3*CBITS    registered colour {R,G,B}; zero outside the active area
//  frame_start out 1         high for the one cycle in which the outputs show pixel (0,0)
// BEHAVIOUR
//  Counters:
//   - h_pos counts 0..HT-1 and wraps to 0. v_pos increments when h_pos wraps.
//   - v_pos wraps VT-1 -> 0 together with h_pos. Frame wrap = the edge where (HT-1,VT-1) -> (0,0).
//  Sync and active area (evaluated on the counters, then registered):
//   - hs asserted for H_ACTIVE+H_FP <= h_pos < H_ACTIVE+H_FP+H_SYNC.
//   - vs asserted for V_ACTIVE+V_FP <= v_pos < V_ACTIVE+V_FP+V_SYNC.
//   - active = h_pos < H_ACTIVE && v_pos < V_ACTIVE.
//  Latency: hs/vs/rgb/frame_start are exactly one cycle behind h_pos/v_pos.
//  Modes (from the active config), each applied only while active; otherwise rgb = 0:
//   - 0: rgb = src_rand.
//   - 1: rgb = fg.
//   - 2: rgb = src_char ? fg : bg.
//   - 3: colour bars. b = h_pos[MSB:MSB-2], MSB = clog2(HT)-1. R = {CBITS{b[2]}}, G = {CBITS{b[1]}}, B = {CBITS{b[0]}}.
//  Config double buffer:
//   - cfg_wr: pending <= cfg_data, cfg_pending <= 1. A later write before frame wrap overwrites; last write wins.
//   - Frame wrap edge with cfg_pending = 1: active_cfg <= pending, cfg_pending <= 0.
//   - cfg_wr on the frame wrap edge: active_cfg takes the old pending word. pending takes cfg_data and
//     cfg_pending stays 1, so the new word applies at the next frame.
//   - Frame wrap with cfg_pending = 0: active_cfg unchanged.
//  Reset (sync, any cycle, including mid-line or mid-frame); the next edge gives:
//   - h_pos = v_pos = 0; hs = vs = deasserted (level ~SYNC_POL); rgb = 0; frame_start = 0; cfg_pending = 0.
//   - active_cfg: mode 0, fg all ones, bg 0. pending = same value.
//   - First frame_start pulse is the cycle after reset is released.
//  Widths: counters sized clog2(HT) / clog2(VT); no overflow beyond HT-1 / VT-1 under any input.
// TESTING
//  1 Defaults, free run 2 frames -> hs period 800 cycles, 96 asserted (low); vs asserted 1600 cycles;
//    frame_start every 420000 cycles; rgb 0 in blanking.
//  2 Mode 1, fg=6'b110000, written mid-frame -> rgb unchanged until next frame_start, then
//    110000 on every active pixel; cfg_pending 1 -> 0 at the wrap edge.
//  3 Mode 2, fg=111111, bg=000011, src_char alternating per cycle -> rgb alternates 111111/000011
//    one cycle later; 0 outside the active area.
//  4 Two writes in one frame (mode 1 fg=001100, then fg=000011) -> only 000011 appears; a write
//    coincident with the wrap edge -> applied one frame later.
//  5 Mode 3, CBITS=2 -> h_pos 0..127 gives rgb 000000; 128..255 gives 000011; 256..383 gives 001100;
//    384..511 gives 001111; 512..639 gives 110000.
//  6 rst pulsed at h_pos=300, v_pos=200 with a write pending -> next edge: counters 0, sync deasserted,
//    rgb 0, cfg_pending 0; random mode resumes.

Source files
------------

// File: rtl/vga_pixel_engine.sv
// ============================================================================
//  Module      : vga_pixel_engine
//  Description : Parametrised VGA timing generator with a four-mode colour
//                selector and a frame-synchronous double-buffered config word.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_pixel_engine #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CBITS    = 2,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   cfg_wr,
    input  logic [31:0]                                            cfg_data,
    output logic                                                   cfg_pending,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]           h_pos,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]           v_pos,
    input  logic [3*CBITS-1:0]                                     src_rand,
    input  logic                                                   src_char,
    output logic                                                   hs,
    output logic                                                   vs,
    output logic [3*CBITS-1:0]                                     rgb,
    output logic                                                   frame_start
);

    localparam int c_HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW = $clog2(c_HT);
    localparam int c_VW = $clog2(c_VT);
    localparam int c_CW = 3 * CBITS;

    localparam logic [c_HW-1:0] c_H_LAST    = c_HW'(c_HT - 1);
    localparam logic [c_VW-1:0] c_V_LAST    = c_VW'(c_VT - 1);
    localparam logic [c_HW-1:0] c_H_ACT     = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_H_SYNC_LO = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_H_SYNC_HI = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_VW-1:0] c_V_ACT     = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_V_SYNC_LO = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_V_SYNC_HI = c_VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0] c_MODE_RAND = 2'd0;
    localparam logic [1:0] c_MODE_FG   = 2'd1;
    localparam logic [1:0] c_MODE_CHAR = 2'd2;
    localparam logic [1:0] c_MODE_BARS = 2'd3;

    logic [c_HW-1:0] r_h;
    logic [c_VW-1:0] r_v;

    logic [1:0]      r_act_mode, r_pend_mode;
    logic [c_CW-1:0] r_act_fg,   r_pend_fg;
    logic [c_CW-1:0] r_act_bg,   r_pend_bg;
    logic            r_pending;

    logic            r_hs, r_vs, r_fs;
    logic [c_CW-1:0] r_rgb;

    logic            w_h_wrap, w_frame_wrap;
    logic            w_active, w_hs_on, w_vs_on;
    logic [2:0]      w_bar;
    logic [c_CW-1:0] w_colour;
    logic            w_cfg_unused;

    assign w_cfg_unused = ^cfg_data[29:6*CBITS];

    assign w_h_wrap     = (r_h == c_H_LAST);
    assign w_frame_wrap = w_h_wrap && (r_v == c_V_LAST);

    // Counters: h wraps every line, v advances on h wrap and wraps with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_wrap) begin
            r_h <= '0;
            r_v <= (r_v == c_V_LAST) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign w_active = (r_h < c_H_ACT) && (r_v < c_V_ACT);
    assign w_hs_on  = (r_h >= c_H_SYNC_LO) && (r_h < c_H_SYNC_HI);
    assign w_vs_on  = (r_v >= c_V_SYNC_LO) && (r_v < c_V_SYNC_HI);
    assign w_bar    = r_h[c_HW-1 -: 3];

    always_comb begin
        w_colour = '0;
        if (w_active) begin
            case (r_act_mode)
                c_MODE_RAND: w_colour = src_rand;
                c_MODE_FG:   w_colour = r_act_fg;
                c_MODE_CHAR: w_colour = src_char ? r_act_fg : r_act_bg;
                c_MODE_BARS: w_colour = {{CBITS{w_bar[2]}}, {CBITS{w_bar[1]}}, {CBITS{w_bar[0]}}};
                default:     w_colour = '0;
            endcase
        end
    end

    // Outputs trail the counters by one cycle so they line up with pixel data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs  <= ~SYNC_POL;
            r_vs  <= ~SYNC_POL;
            r_fs  <= 1'b0;
            r_rgb <= '0;
        end else begin
            r_hs  <= w_hs_on ? SYNC_POL : ~SYNC_POL;
            r_vs  <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            r_fs  <= (r_h == '0) && (r_v == '0);
            r_rgb <= w_colour;
        end
    end

    // Pending word moves to active only on the frame wrap; a write on that same
    // edge lands in pending and waits for the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_mode  <= c_MODE_RAND;
            r_act_fg    <= '1;
            r_act_bg    <= '0;
            r_pend_mode <= c_MODE_RAND;
            r_pend_fg   <= '1;
            r_pend_bg   <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (w_frame_wrap && r_pending) begin
                r_act_mode <= r_pend_mode;
                r_act_fg   <= r_pend_fg;
                r_act_bg   <= r_pend_bg;
                r_pending  <= 1'b0;
            end
            if (cfg_wr) begin
                r_pend_mode <= cfg_data[31:30];
                r_pend_fg   <= cfg_data[6*CBITS-1:3*CBITS];
                r_pend_bg   <= cfg_data[3*CBITS-1:0];
                r_pending   <= 1'b1;
            end
        end
    end

    assign h_pos       = r_h;
    assign v_pos       = r_v;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign rgb         = r_rgb;
    assign frame_start = r_fs;
    assign cfg_pending = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_engine.sv
// ============================================================================
//  Module      : tb_vga_pixel_engine
//  Description : Directed self-checking bench for vga_pixel_engine, default
//                horizontal timing with a shortened 8-line frame (6400 cycles).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_pixel_engine;

    localparam int c_HT = 800;
    localparam int c_VT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [31:0] cfg_data;
    logic        cfg_pending;
    logic [9:0]  h_pos;
    logic [2:0]  v_pos;
    logic [5:0]  src_rand;
    logic        src_char;
    logic        hs, vs;
    logic [5:0]  rgb;
    logic        frame_start;

    int n_checks = 0;
    int n_pass   = 0;

    vga_pixel_engine #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(4),   .V_FP(1),  .V_SYNC(2),  .V_BP(1),
        .CBITS(2),      .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_data(cfg_data),
        .cfg_pending(cfg_pending), .h_pos(h_pos), .v_pos(v_pos),
        .src_rand(src_rand), .src_char(src_char), .hs(hs), .vs(vs),
        .rgb(rgb), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(h_pos == 10'(h) && v_pos == 3'(v)) && n < 7000) begin
            tick();
            n++;
        end
        check("reach_pos", {h_pos, v_pos}, {10'(h), 3'(v)});
    endtask

    task automatic write_cfg(input logic [31:0] d);
        cfg_wr   = 1'b1;
        cfg_data = d;
        tick();
        cfg_wr   = 1'b0;
    endtask

    // mode in [31:30], fg in [11:6], bg in [5:0]
    function automatic logic [31:0] cfg(input logic [1:0] m, input logic [5:0] fg, input logic [5:0] bg);
        return {m, 18'd0, fg, bg};
    endfunction

    initial begin
        int hs_low, vs_low, fs_cnt, blank_bad, act_bad, ph, pv, n;
        rst = 1'b1; cfg_wr = 1'b0; cfg_data = '0; src_rand = 6'b101101; src_char = 1'b0;
        tick(); tick();
        check("rst_h", h_pos, 0);
        check("rst_v", v_pos, 0);
        check("rst_hs", hs, 1);
        check("rst_vs", vs, 1);
        check("rst_rgb", rgb, 0);
        check("rst_fs", frame_start, 0);
        check("rst_pend", cfg_pending, 0);

        rst = 1'b0;
        tick();
        check("first_fs", frame_start, 1);
        check("first_rgb_rand", rgb, 6'b101101);
        check("first_h", h_pos, 1);

        // One full frame of free running in default random mode.
        hs_low = 0; vs_low = 0; fs_cnt = 0; blank_bad = 0; act_bad = 0;
        for (int i = 0; i < 6400; i++) begin
            ph = int'(h_pos); pv = int'(v_pos);
            tick();
            if (!hs) hs_low++;
            if (!vs) vs_low++;
            if (frame_start) fs_cnt++;
            if (ph < 640 && pv < 4) begin
                if (rgb !== src_rand) act_bad++;
            end else if (rgb !== 6'd0) blank_bad++;
        end
        check("hs_low_cycles", hs_low, 96 * 8);
        check("vs_low_cycles", vs_low, 1600);
        check("fs_per_frame", fs_cnt, 1);
        check("blank_rgb_bad", blank_bad, 0);
        check("active_rand_bad", act_bad, 0);

        n = 0;
        do begin tick(); n++; end while (!frame_start && n < 7000);
        check("fs_period", n, 6400);

        run_to(656, 0); check("hs_before", hs, 1);
        tick();         check("hs_start", hs, 0);
        run_to(752, 0); check("hs_last", hs, 0);
        tick();         check("hs_end", hs, 1);

        // Mode 1 written mid-frame, applied only at the next frame.
        run_to(100, 1);
        write_cfg(cfg(2'd1, 6'b110000, 6'd0));
        check("m1_pend", cfg_pending, 1);
        run_to(300, 2); check("m1_not_yet", rgb, 6'b101101);
        run_to(c_HT-1, c_VT-1); check("m1_pend_wrap", cfg_pending, 1);
        tick(); check("m1_pend_clr", cfg_pending, 0);
        tick();
        check("m1_fs", frame_start, 1);
        check("m1_px00", rgb, 6'b110000);
        run_to(300, 2); check("m1_active", rgb, 6'b110000);
        run_to(701, 2); check("m1_blank", rgb, 0);

        // Mode 2 with src_char alternating every cycle.
        write_cfg(cfg(2'd2, 6'b111111, 6'b000011));
        run_to(0, 0); tick();
        run_to(10, 1);
        for (int i = 0; i < 4; i++) begin
            src_char = i[0];
            tick();
            check("m2_alt", rgb, i[0] ? 6'b111111 : 6'b000011);
        end
        src_char = 1'b1;
        run_to(645, 1); check("m2_blank", rgb, 0);

        // Two writes in a frame: the later one wins.
        write_cfg(cfg(2'd1, 6'b001100, 6'd0));
        tick();
        write_cfg(cfg(2'd1, 6'b000011, 6'd0));
        run_to(0, 0); tick();
        check("last_wins_px00", rgb, 6'b000011);
        run_to(50, 0); check("last_wins", rgb, 6'b000011);

        // A pending word plus a write coincident with the wrap edge.
        write_cfg(cfg(2'd1, 6'b111100, 6'd0));
        run_to(c_HT-1, c_VT-1);
        write_cfg(cfg(2'd1, 6'b001111, 6'd0));
        check("wrap_wr_pend", cfg_pending, 1);
        tick();
        check("wrap_wr_old", rgb, 6'b111100);
        run_to(c_HT-1, c_VT-1); tick();
        check("wrap_wr_pend_clr", cfg_pending, 0);
        tick();
        check("wrap_wr_new", rgb, 6'b001111);

        // Mode 3 colour bars.
        write_cfg(cfg(2'd3, 6'd0, 6'd0));
        run_to(0, 0); tick();
        run_to(1, 1);   check("bar_h0", rgb, 6'b000000);
        run_to(128, 1); check("bar_h127", rgb, 6'b000000);
        run_to(129, 1); check("bar_h128", rgb, 6'b000011);
        run_to(257, 1); check("bar_h256", rgb, 6'b001100);
        run_to(385, 1); check("bar_h384", rgb, 6'b001111);
        run_to(513, 1); check("bar_h512", rgb, 6'b110000);
        run_to(640, 1); check("bar_h639", rgb, 6'b110000);
        run_to(641, 1); check("bar_h640", rgb, 6'b000000);

        // Reset mid-frame with a write pending.
        write_cfg(cfg(2'd1, 6'b110000, 6'd0));
        run_to(300, 2);
        check("rst2_pend_before", cfg_pending, 1);
        rst = 1'b1;
        tick();
        check("rst2_h", h_pos, 0);
        check("rst2_v", v_pos, 0);
        check("rst2_hs", hs, 1);
        check("rst2_vs", vs, 1);
        check("rst2_rgb", rgb, 0);
        check("rst2_fs", frame_start, 0);
        check("rst2_pend", cfg_pending, 0);
        rst = 1'b0; src_rand = 6'b010101;
        tick();
        check("rst2_fs_after", frame_start, 1);
        check("rst2_rand", rgb, 6'b010101);
        run_to(c_HT-1, c_VT-1); tick(); tick();
        check("rst2_rand_next", rgb, 6'b010101);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
